// File: rtl/reverb_param_sequencer.sv
// reverb_param_sequencer
// Turns increment/decrement requests from the control PIOs into saturated
// updates of the reverb core parameters (predelay, decay, damping, mix).
// Updates commit on an audio sample boundary, so the datapath never sees a
// value change in the middle of a sample.
//
// Build option PARAM_SEQ_TICK_SYNC_EN:
//   defined   - a computed update waits in WAIT_TICK for sample_tick
//   undefined - WAIT_TICK is not built, sample_tick is ignored and the
//               update loads straight out of CALC
//
// Request handshake: param_update is a level request. Each rising edge on
// exactly one bit is one event. The pending slot holds one event until the
// FSM takes it in IDLE; an event that arrives while the slot is full is lost
// and raises the sticky event_dropped flag.
module reverb_param_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  param_type,
    input  logic [1:0]  param_update,
    input  logic        sample_tick,
    input  logic        clear_drop,
    output logic [9:0]  predelay_value,
    output logic [24:0] decay_value,
    output logic [24:0] damping_value,
    output logic [23:0] mix_value,
    output logic        busy,
    output logic        update_ack,
    output logic        event_dropped
);

    localparam logic [9:0]  PREDELAY_MAX  = 10'd1023;
    localparam logic [9:0]  PREDELAY_STEP = 10'd16;
    localparam logic [24:0] COEF_MAX      = 25'h1000000;
    localparam logic [24:0] COEF_STEP     = 25'h051EB8;
    localparam logic [24:0] DECAY_RST     = 25'h0B33333;
    localparam logic [24:0] DAMP_RST      = 25'h0400000;
    localparam logic [23:0] MIX_MAX       = 24'hFFFFFF;
    localparam logic [23:0] MIX_STEP      = 24'h0CCCCC;
    localparam logic [23:0] MIX_RST       = 24'h800000;

`ifdef PARAM_SEQ_TICK_SYNC_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, WAIT_TICK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1} state_t;
`endif

    state_t      state;
    logic [1:0]  upd_q;
    logic [1:0]  rise;
    logic        evt;
    logic        pend_valid;
    logic [3:0]  pend_type;
    logic        pend_dir;     // 1 = decrement
    logic [3:0]  act_type;
    logic        act_dir;
    logic [24:0] staged;
    logic        consume;
    logic        type_ok;
    logic [25:0] cur;
    logic [25:0] max_v;
    logic [25:0] step_v;
    logic [25:0] next_v;
    logic [24:0] load_val;
    logic        load_en;

    // Saturating step in one extra bit so the compares never wrap.
    function automatic logic [25:0] step_sat(input logic [25:0] c, input logic [25:0] m,
                                             input logic [25:0] s, input logic dec);
        if (dec)
            return (c < s) ? 26'd0 : c - s;
        else
            return (c > m - s) ? m : c + s;
    endfunction

    assign rise    = param_update & ~upd_q;
    assign evt     = (rise == 2'b01) || (rise == 2'b10);
    assign consume = (state == IDLE) && pend_valid;
    assign type_ok = (pend_type != 4'd0) && ((pend_type & (pend_type - 4'd1)) == 4'd0);
    assign busy    = (state != IDLE);

    // Select live value and limits of the parameter being updated.
    always_comb begin
        cur    = 26'd0;
        max_v  = 26'd0;
        step_v = 26'd0;
        if (act_type[0]) begin
            cur    = {16'd0, predelay_value};
            max_v  = {16'd0, PREDELAY_MAX};
            step_v = {16'd0, PREDELAY_STEP};
        end else if (act_type[1]) begin
            cur    = {1'b0, decay_value};
            max_v  = {1'b0, COEF_MAX};
            step_v = {1'b0, COEF_STEP};
        end else if (act_type[2]) begin
            cur    = {1'b0, damping_value};
            max_v  = {1'b0, COEF_MAX};
            step_v = {1'b0, COEF_STEP};
        end else if (act_type[3]) begin
            cur    = {2'd0, mix_value};
            max_v  = {2'd0, MIX_MAX};
            step_v = {2'd0, MIX_STEP};
        end
        next_v = step_sat(cur, max_v, step_v, act_dir);
    end

`ifdef PARAM_SEQ_TICK_SYNC_EN
    assign load_en  = (state == WAIT_TICK) && sample_tick;
    assign load_val = staged;
`else
    logic unused_tick;
    assign unused_tick = sample_tick;
    assign load_en     = (state == CALC);
    assign load_val    = next_v[24:0];
`endif

    // Edge detect, single-entry pending slot and sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_q         <= 2'b00;
            pend_valid    <= 1'b0;
            pend_type     <= 4'd0;
            pend_dir      <= 1'b0;
            event_dropped <= 1'b0;
        end else begin
            upd_q <= param_update;
            if (evt && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_type  <= param_type;
                pend_dir   <= rise[1];
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
            if (evt && pend_valid)
                event_dropped <= 1'b1;
            else if (clear_drop)
                event_dropped <= 1'b0;
        end
    end

    // Sequencer FSM: take entry, compute staged value, commit on boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            act_type   <= 4'd0;
            act_dir    <= 1'b0;
            staged     <= 25'd0;
            update_ack <= 1'b0;
        end else begin
            update_ack <= load_en;
            case (state)
                IDLE: begin
                    if (consume && type_ok) begin
                        act_type <= pend_type;
                        act_dir  <= pend_dir;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    staged <= next_v[24:0];
`ifdef PARAM_SEQ_TICK_SYNC_EN
                    state  <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (sample_tick)
                        state <= IDLE;
`else
                    state  <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Live parameter registers; only the selected one changes on commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            predelay_value <= 10'd0;
            decay_value    <= DECAY_RST;
            damping_value  <= DAMP_RST;
            mix_value      <= MIX_RST;
        end else if (load_en) begin
            if (act_type[0]) predelay_value <= load_val[9:0];
            if (act_type[1]) decay_value    <= load_val;
            if (act_type[2]) damping_value  <= load_val;
            if (act_type[3]) mix_value      <= load_val[23:0];
        end
    end

endmodule

// File: tb/tb_reverb_param_sequencer.sv
// Directed bench for reverb_param_sequencer; follows PARAM_SEQ_TICK_SYNC_EN
// the same way the design does.
module tb_reverb_param_sequencer;

    localparam logic [31:0] DECAY_RST = 32'h0B33333;
    localparam logic [31:0] DAMP_RST  = 32'h0400000;
    localparam logic [31:0] MIX_RST   = 32'h800000;
    localparam logic [31:0] COEF_STEP = 32'h051EB8;
    localparam logic [31:0] COEF_MAX  = 32'h1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  param_type = 4'd0;
    logic [1:0]  param_update = 2'd0;
    logic        sample_tick = 1'b0;
    logic        clear_drop = 1'b0;
    logic [9:0]  predelay_value;
    logic [24:0] decay_value;
    logic [24:0] damping_value;
    logic [23:0] mix_value;
    logic        busy;
    logic        update_ack;
    logic        event_dropped;

    int checks = 0;
    int errors = 0;

    reverb_param_sequencer dut (
        .clk(clk), .reset(reset), .param_type(param_type), .param_update(param_update),
        .sample_tick(sample_tick), .clear_drop(clear_drop),
        .predelay_value(predelay_value), .decay_value(decay_value),
        .damping_value(damping_value), .mix_value(mix_value),
        .busy(busy), .update_ack(update_ack), .event_dropped(event_dropped)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pd"},   {22'd0, predelay_value}, 32'd0);
        chk({tag, "_dec"},  {7'd0, decay_value},     DECAY_RST);
        chk({tag, "_damp"}, {7'd0, damping_value},   DAMP_RST);
        chk({tag, "_mix"},  {8'd0, mix_value},       MIX_RST);
        chk({tag, "_busy"}, {31'd0, busy},           32'd0);
        chk({tag, "_ack"},  {31'd0, update_ack},     32'd0);
        chk({tag, "_drop"}, {31'd0, event_dropped},  32'd0);
    endtask

    // One request edge followed by its commit; param_type is scrambled after
    // capture to show the latched type is used.
    task automatic do_update(input logic [3:0] t, input logic [1:0] u);
        @(negedge clk); param_type = t; param_update = u;
        @(negedge clk); param_update = 2'b00; param_type = 4'b1111;
        @(negedge clk); chk("busy_calc", {31'd0, busy}, 32'd1);
`ifdef PARAM_SEQ_TICK_SYNC_EN
        @(negedge clk); chk("no_ack_wait", {31'd0, update_ack}, 32'd0); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
`else
        @(negedge clk);
`endif
        chk("ack_commit", {31'd0, update_ack}, 32'd1);
        chk("busy_commit", {31'd0, busy}, 32'd0);
        @(negedge clk); chk("ack_once", {31'd0, update_ack}, 32'd0);
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        // predelay increment
`ifdef PARAM_SEQ_TICK_SYNC_EN
        @(negedge clk); param_type = 4'b0001; param_update = 2'b01;
        @(negedge clk); param_update = 2'b00; param_type = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pd_before_tick", {22'd0, predelay_value}, 32'd0);
            chk("ack_before_tick", {31'd0, update_ack}, 32'd0);
        end
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        chk("pd_tick_val", {22'd0, predelay_value}, 32'd16);
        chk("pd_tick_ack", {31'd0, update_ack}, 32'd1);
        @(negedge clk);
        chk("pd_ack_once", {31'd0, update_ack}, 32'd0);
`else
        do_update(4'b0001, 2'b01);
`endif
        chk("pd_inc", {22'd0, predelay_value}, 32'd16);

        // decay saturation
        for (int i = 0; i < 5; i++) do_update(4'b0010, 2'b01);
        chk("decay_5inc", {7'd0, decay_value}, DECAY_RST + 5 * COEF_STEP);
        for (int i = 0; i < 13; i++) do_update(4'b0010, 2'b01);
        chk("decay_clamp", {7'd0, decay_value}, COEF_MAX);

        // mix floor
        for (int i = 0; i < 64; i++) do_update(4'b1000, 2'b10);
        chk("mix_floor", {8'd0, mix_value}, 32'd0);
        chk("pd_untouched", {22'd0, predelay_value}, 32'd16);
        chk("damp_untouched", {7'd0, damping_value}, DAMP_RST);

        // invalid: multi-hot type, then both bits rising together
        @(negedge clk); param_type = 4'b0011; param_update = 2'b01;
        @(negedge clk); param_update = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("inv_type_busy", {31'd0, busy}, 32'd0);
            chk("inv_type_ack", {31'd0, update_ack}, 32'd0);
        end
        @(negedge clk); param_type = 4'b0001; param_update = 2'b11;
        @(negedge clk); param_update = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("inv_both_busy", {31'd0, busy}, 32'd0);
            chk("inv_both_ack", {31'd0, update_ack}, 32'd0);
        end
        chk("inv_pd", {22'd0, predelay_value}, 32'd16);
        chk("inv_dec", {7'd0, decay_value}, COEF_MAX);
        chk("inv_mix", {8'd0, mix_value}, 32'd0);
        chk("inv_drop", {31'd0, event_dropped}, 32'd0);

        // three damping increments two cycles apart
        @(negedge clk); param_type = 4'b0100; param_update = 2'b01;
        @(negedge clk); param_update = 2'b00;
        @(negedge clk); param_update = 2'b01;
        @(negedge clk); param_update = 2'b00;
        @(negedge clk); param_update = 2'b01;
        @(negedge clk); param_update = 2'b00;
`ifdef PARAM_SEQ_TICK_SYNC_EN
        chk("ovf_drop_set", {31'd0, event_dropped}, 32'd1);
        chk("ovf_hold", {7'd0, damping_value}, DAMP_RST);
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        chk("ovf_ack1", {31'd0, update_ack}, 32'd1);
        chk("ovf_val1", {7'd0, damping_value}, DAMP_RST + COEF_STEP);
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        chk("ovf_ack2", {31'd0, update_ack}, 32'd1);
        chk("ovf_val2", {7'd0, damping_value}, DAMP_RST + 2 * COEF_STEP);
        chk("ovf_drop_sticky", {31'd0, event_dropped}, 32'd1);
        clear_drop = 1'b1;
        @(negedge clk); clear_drop = 1'b0;
        chk("ovf_drop_clr", {31'd0, event_dropped}, 32'd0);
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        chk("ovf_no_third", {31'd0, update_ack}, 32'd0);
        chk("ovf_final", {7'd0, damping_value}, DAMP_RST + 2 * COEF_STEP);
`else
        repeat (4) @(negedge clk);
        chk("burst_final", {7'd0, damping_value}, DAMP_RST + 3 * COEF_STEP);
        chk("burst_no_drop", {31'd0, event_dropped}, 32'd0);
`endif

        // reset in the middle of an update
        @(negedge clk); param_type = 4'b1000; param_update = 2'b01;
        @(negedge clk); param_update = 2'b00;
        @(negedge clk);
`ifdef PARAM_SEQ_TICK_SYNC_EN
        @(negedge clk);
`endif
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("mid_rst");
        @(negedge clk); reset = 1'b0;
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_ack", {31'd0, update_ack}, 32'd0);
            @(negedge clk);
        end
        chk("post_rst_mix", {8'd0, mix_value}, MIX_RST);

        // mix increment from reset value
        do_update(4'b1000, 2'b01);
        chk("mix_inc", {8'd0, mix_value}, 32'h8CCCCC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
